// File: rtl/pmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pmem_responder                                                   |
// | Brief    : Line-organised physical memory answering the cache pmem_*         |
// |            handshake after a fixed, parameterised latency.                  |
// | Revision : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module pmem_responder #(
    parameter int LINE_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 12,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  pmem_error
);

    localparam int         c_depth      = 1 << INDEX_BITS;
    localparam logic       c_single     = (LATENCY == 1);
    localparam logic [7:0] c_count_load = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    generate
        if ((LATENCY < 1) || (LATENCY > 255)) begin : g_latency_range_error
            $error("pmem_responder: LATENCY must be in 1..255");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [7:0]            r_count;
    logic [INDEX_BITS-1:0] r_index;
    logic                  r_is_write;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_error;
    logic [LINE_WIDTH-1:0] r_mem [c_depth];

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_error_set;
    logic                  w_req_held;
    logic [INDEX_BITS-1:0] w_addr_index;
    logic [INDEX_BITS-1:0] w_op_index;
    logic                  w_op_write;
    logic [LINE_WIDTH-1:0] w_op_wdata;
    logic [ADDR_WIDTH-1:0] w_unused_addr;

    assign w_unused_addr = pmem_address;
    assign w_addr_index  = pmem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign w_req_held    = r_is_write ? pmem_write : pmem_read;

    // With single-cycle latency the operation completes on its accept edge,
    // so the live request fields stand in for the not-yet-latched ones.
    assign w_op_index = w_accept ? w_addr_index : r_index;
    assign w_op_write = w_accept ? pmem_write   : r_is_write;
    assign w_op_wdata = w_accept ? pmem_wdata   : r_wdata;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_error_set  = 1'b0;
        case (r_state)
            c_idle: begin
                if (pmem_read && pmem_write) begin
                    w_error_set = 1'b1;
                end else if (pmem_read || pmem_write) begin
                    w_accept = 1'b1;
                    if (c_single) begin
                        w_complete   = 1'b1;
                        w_next_state = c_resp;
                    end else begin
                        w_next_state = c_wait;
                    end
                end
            end
            c_wait: begin
                w_error_set = !w_req_held;
                if (r_count == 8'd0) begin
                    w_complete   = 1'b1;
                    w_next_state = c_resp;
                end
            end
            c_resp: begin
                w_error_set  = !w_req_held;
                w_next_state = c_idle;
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_count    <= 8'd0;
            r_index    <= '0;
            r_is_write <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_index    <= w_addr_index;
                r_is_write <= pmem_write;
                r_wdata    <= pmem_wdata;
                r_count    <= c_count_load;
            end else if ((r_state == c_wait) && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end
            if (w_error_set) begin
                r_error <= 1'b1;
            end
            if (w_complete && !w_op_write) begin
                r_rdata <= r_mem[w_op_index];
            end
        end
    end

    // Array is never cleared; reset only suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (!reset && w_complete && w_op_write) begin
            r_mem[w_op_index] <= w_op_wdata;
        end
    end

    assign pmem_resp  = (r_state == c_resp);
    assign pmem_rdata = r_rdata;
    assign pmem_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_pmem_responder                                                |
// | Brief    : Directed self-checking bench for pmem_responder.                 |
// | Revision : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         rst, rst1;
    logic [15:0]  addr, addr1;
    logic         rd, wr, rd1, wr1;
    logic [127:0] wdata, wdata1;
    logic [127:0] rdata, rdata1;
    logic         resp, resp1, err, err1;

    int n_pass  = 0;
    int n_total = 0;
    int n_resp  = 0;
    int n_resp1 = 0;

    localparam logic [127:0] c_line  = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] c_line2 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [127:0] c_pre0  = 128'h00000000_11111111_22222222_33333333;
    localparam logic [127:0] c_pre1  = 128'hA5A5A5A5_5A5A5A5A_0123ABCD_FEDC3210;

    pmem_responder #(.LATENCY(4)) dut (
        .clk(clk), .reset(rst), .pmem_address(addr), .pmem_read(rd), .pmem_write(wr),
        .pmem_wdata(wdata), .pmem_rdata(rdata), .pmem_resp(resp), .pmem_error(err)
    );

    pmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .pmem_address(addr1), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_wdata(wdata1), .pmem_rdata(rdata1), .pmem_resp(resp1), .pmem_error(err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp)  n_resp  = n_resp + 1;
        if (resp1) n_resp1 = n_resp1 + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        addr = '0; addr1 = '0; rd = 0; wr = 0; rd1 = 0; wr1 = 0;
        wdata = '0; wdata1 = '0;
        for (int i = 0; i < 4096; i++) begin
            dut.r_mem[i]  = '0;
            dut1.r_mem[i] = '0;
        end
        dut1.r_mem[0] = c_pre0;
        dut1.r_mem[1] = c_pre1;

        tick(); tick();
        check("reset_resp",  {127'd0, resp},  128'd0);
        check("reset_rdata", rdata,           128'd0);
        check("reset_error", {127'd0, err},   128'd0);
        rst = 1'b0; rst1 = 1'b0;
        tick();

        // Read of index 0x012: single pulse at T+4 with zero data
        n_resp = 0;
        addr = 16'h0120; rd = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("rd0_resp_c%0d", c), {127'd0, resp}, {127'd0, (c == 4)});
        end
        check("rd0_rdata", rdata, 128'd0);
        check("rd0_error", {127'd0, err}, 128'd0);
        tick();
        rd = 0;
        check("rd0_resp_after", {127'd0, resp}, 128'd0);
        check("rd0_pulses", 128'(n_resp), 128'd1);

        // Write then immediate read-back through an aliased offset
        n_resp = 0;
        addr = 16'h0340; wdata = c_line; wr = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("wr_resp_c%0d", c), {127'd0, resp}, {127'd0, (c == 4)});
        end
        check("wr_rdata_unchanged", rdata, 128'd0);
        tick();
        wr = 0; rd = 1; addr = 16'h034F; wdata = c_line2;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("rb_resp_c%0d", c), {127'd0, resp}, {127'd0, (c == 4)});
        end
        check("rb_rdata", rdata, c_line);
        tick();
        rd = 0;
        check("rb_pulses", 128'(n_resp), 128'd2);
        check("rb_error", {127'd0, err}, 128'd0);

        // Conflicting read+write in IDLE
        n_resp = 0;
        rd = 1; wr = 1;
        tick();
        check("conf_error_c1", {127'd0, err}, 128'd1);
        tick();
        rd = 0; wr = 0;
        tick(); tick(); tick(); tick();
        check("conf_no_resp", 128'(n_resp), 128'd0);
        check("conf_error_sticky", {127'd0, err}, 128'd1);
        rst = 1;
        tick();
        rst = 0;
        check("conf_error_cleared", {127'd0, err}, 128'd0);
        tick();

        // Reset during the WAIT phase of a write discards it
        n_resp = 0;
        addr = 16'h0340; wdata = c_line2; wr = 1;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; wr = 0;
        check("abort_resp",  {127'd0, resp}, 128'd0);
        check("abort_rdata", rdata, 128'd0);
        check("abort_error", {127'd0, err}, 128'd0);
        tick(); tick(); tick(); tick();
        check("abort_no_resp", 128'(n_resp), 128'd0);
        addr = 16'h0340; rd = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("abort_rd_resp_c%0d", c), {127'd0, resp}, {127'd0, (c == 4)});
        end
        check("abort_rd_rdata", rdata, c_line);
        tick();
        rd = 0;
        tick();

        // Requester drops pmem_read at T+2
        n_resp = 0;
        addr = 16'h0120; rd = 1;
        tick(); tick();
        rd = 0;
        tick();
        check("drop_resp_c3", {127'd0, resp}, 128'd0);
        tick();
        check("drop_resp_c4", {127'd0, resp}, 128'd1);
        check("drop_error",   {127'd0, err},  128'd1);
        check("drop_rdata",   rdata, 128'd0);
        tick();
        check("drop_pulses", 128'(n_resp), 128'd1);

        // Single-cycle latency, back-to-back reads of preloaded lines
        n_resp1 = 0;
        addr1 = 16'h0000; rd1 = 1;
        tick();
        check("l1_resp_t1",  {127'd0, resp1}, 128'd1);
        check("l1_rdata_t1", rdata1, c_pre0);
        addr1 = 16'h0010;
        tick();
        check("l1_resp_t2",  {127'd0, resp1}, 128'd0);
        tick();
        check("l1_resp_t3",  {127'd0, resp1}, 128'd1);
        check("l1_rdata_t3", rdata1, c_pre1);
        tick();
        rd1 = 0;
        tick();
        check("l1_pulses", 128'(n_resp1), 128'd2);
        check("l1_error",  {127'd0, err1}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmem_responder.md
# pmem_responder

Physical-memory responder for the LC-3b cache hierarchy: the memory-side end of the `pmem_read`/`pmem_write`/`pmem_resp` line-transfer handshake driven by the cache controller. It accepts one 128-bit line read or write at a time and services it from an internal line-organised storage array. It responds after a fixed, parameterised latency. It sits between the cache and the top-level testbench/board memory and replaces the ideal behavioural memory.

## Interface
- `LINE_WIDTH`, default 128: bits per cache line.
- `ADDR_WIDTH`, default 16: byte address width.
- `OFFSET_BITS`, default 4: line-offset bits; these are ignored for indexing.
- `INDEX_BITS`, default 12: line-index bits; depth is 2^INDEX_BITS lines.
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pmem_address` in ADDR_WIDTH: byte address of the line; the index is `[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]`.
- `pmem_read` in 1: line read request, held until `pmem_resp`.
- `pmem_write` in 1: line write request, held until `pmem_resp`.
- `pmem_wdata` in LINE_WIDTH: write line, stable while `pmem_write` is high.
- `pmem_rdata` out LINE_WIDTH: read line, valid in the `pmem_resp` cycle of a read.
- `pmem_resp` out 1: single-cycle completion pulse.
- `pmem_error` out 1: sticky protocol-violation flag.

## Operation
- FSM states:
  - `IDLE`: waiting for a request.
  - `WAIT`: latency countdown.
  - `RESP`: response cycle.
- `IDLE` behaviour:
  - Exactly one of `pmem_read`/`pmem_write` high: latch index, op, and `pmem_wdata`.
  - If `LATENCY`==1, go to `RESP`. Otherwise load the 8-bit counter with `LATENCY-2` and go to `WAIT`.
  - Both `pmem_read` and `pmem_write` high: set `pmem_error`, accept nothing, stay in `IDLE`.
- `WAIT` behaviour:
  - Counter at 0: go to `RESP`. Otherwise decrement.
  - On the `WAIT`→`RESP` edge (or the `IDLE`→`RESP` edge when `LATENCY`==1):
    - Read: `pmem_rdata` <= array[latched index].
    - Write: array[latched index] <= latched wdata.
- `RESP` behaviour:
  - `pmem_resp`=1 for exactly this cycle, then go unconditionally to `IDLE`.
- Request-line requirement: the requester must keep its request line high through the `RESP` cycle.
  - Request line low in any `WAIT` cycle, or in the `RESP` cycle: set `pmem_error`.
  - The transaction still completes, including the array write.
  - Address or data changes after acceptance are ignored; the latched values are used.
- Back-to-back requests:
  - A request seen in `IDLE` the cycle after `RESP` is a new transaction.
  - This supports the controller going from write-back `pmem_resp` straight to a line fetch.
- `pmem_rdata` holds its value until the next read completes; writes do not change it.
- Read-after-write to the same index returns the newly written line.
- Address aliasing: address bits above `OFFSET_BITS+INDEX_BITS` are ignored.
- Array contents:
  - Not cleared by `reset`.
  - Simulation initial contents are all zero.
  - The array may be preloaded via `$readmemh` in the bench.

## Timing
- Reset values: state `IDLE`, `pmem_resp`=0, `pmem_rdata`=0, `pmem_error`=0, counter=0.
- Reset mid-transaction:
  - The transaction is aborted with no response.
  - A pending write is discarded; the array is unchanged.
- Latency:
  - Request first high in `IDLE` at cycle T: `pmem_resp` high at cycle T+`LATENCY` only.
  - Minimum turnaround between responses is `LATENCY`+1 cycles.
- `pmem_resp` is registered: asserted from the state, no combinational path from the request inputs.
- `pmem_error` is sticky until `reset`.
- Counter width is 8 bits; `LATENCY`=0 or >255 is an elaboration error (assertion).

## Test plan
- Reset, then read index 0x012 (`pmem_address`=0x0120) with `LATENCY`=4:
  - `pmem_resp` pulses once at T+4 with `pmem_rdata`=0.
  - `pmem_error`=0.
- Write 0xDEADBEEF_00112233_44556677_8899AABB to 0x0340, then read 0x034F one cycle after that `pmem_resp`:
  - The read returns the same line at T'+4.
  - Exactly two `pmem_resp` pulses.
- `pmem_read` and `pmem_write` both high for 2 cycles in `IDLE`:
  - No `pmem_resp`; `pmem_error`=1 and stays 1 until `reset`.
- Write in flight; `reset` asserted in `WAIT` (cycle T+2):
  - `pmem_resp` never pulses; outputs return to reset values.
  - A later read of that index returns the old contents.
- Requester drops `pmem_read` at T+2:
  - `pmem_resp` still pulses at T+4.
  - `pmem_error`=1.
- `LATENCY`=1, back-to-back reads of 0x0000 and 0x0010:
  - `pmem_resp` at T+1 and T+3.
  - Each with the correct preloaded line.
